// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - load/store request bus and synchronous RAM port bundle
interface data_mem_ctrl_if #(
  parameter int RAM_AWORDS = 10
);
  logic [31:0]           addr_i;
  logic [31:0]           wdata_i;
  logic                  memwrite_i;
  logic                  memread_i;
  logic [2:0]            sign_mask_i;
  logic [31:0]           rdata_o;
  logic [RAM_AWORDS-1:0] ram_addr_o;
  logic [31:0]           ram_wdata_o;
  logic [3:0]            ram_be_o;
  logic                  ram_we_o;
  logic [31:0]           ram_rdata_i;

  modport slave (
    input  addr_i, wdata_i, memwrite_i, memread_i, sign_mask_i, ram_rdata_i,
    output rdata_o, ram_addr_o, ram_wdata_o, ram_be_o, ram_we_o
  );

  modport master (
    output addr_i, wdata_i, memwrite_i, memread_i, sign_mask_i, ram_rdata_i,
    input  rdata_o, ram_addr_o, ram_wdata_o, ram_be_o, ram_we_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data memory controller: RAM window, LED register, cycle counter
module data_mem_ctrl #(
  parameter int          RAM_AWORDS = 10,
  parameter logic [31:0] RAM_BASE   = 32'h0000_1000,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_2000
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  data_mem_ctrl_if.slave  bus,
  output logic [7:0]      led_o,
  output logic            misalign_o
);
  localparam logic [1:0]  REG_NONE = 2'd0;
  localparam logic [1:0]  REG_RAM  = 2'd1;
  localparam logic [1:0]  REG_LED  = 2'd2;
  localparam logic [1:0]  REG_CNT  = 2'd3;
  localparam logic [32:0] RAM_END  = {1'b0, RAM_BASE} + (33'd4 << RAM_AWORDS);
  localparam logic [31:0] CNT_ADDR = MMIO_BASE + 32'd4;

  logic [1:0]  region;
  logic [1:0]  off;
  logic [1:0]  size;
  logic        is_byte;
  logic        is_half;
  logic        mis;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] cnt_q;
  logic [1:0]  rd_region_q;
  logic [1:0]  rd_off_q;
  logic [2:0]  rd_sm_q;
  logic        rd_mis_q;
  logic [31:0] rd_snap_q;
  logic [31:0] src;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] rdata;

  assign off     = bus.addr_i[1:0];
  assign size    = bus.sign_mask_i[1:0];
  assign is_byte = (size == 2'b01);
  assign is_half = (size == 2'b10);
  // size 00 is treated as a word access
  assign mis     = (is_half && off[0]) || (!is_byte && !is_half && off != 2'b00);

  // Region decode; RAM window checked with a 33-bit end so a window at the top of memory does not wrap
  always_comb begin
    region = REG_NONE;
    if (bus.addr_i >= RAM_BASE && {1'b0, bus.addr_i} < RAM_END)
      region = REG_RAM;
    else if (bus.addr_i[31:2] == MMIO_BASE[31:2])
      region = REG_LED;
    else if (bus.addr_i[31:2] == CNT_ADDR[31:2])
      region = REG_CNT;
  end

  // Byte enables and lane replication of store data
  always_comb begin
    be    = 4'b1111;
    wdata = bus.wdata_i;
    if (is_byte) begin
      be    = 4'b0001 << off;
      wdata = {4{bus.wdata_i[7:0]}};
    end else if (is_half) begin
      be    = 4'b0011 << off;
      wdata = {2{bus.wdata_i[15:0]}};
    end
  end

  assign bus.ram_addr_o  = bus.addr_i[RAM_AWORDS+1:2] - RAM_BASE[RAM_AWORDS+1:2];
  assign bus.ram_be_o    = be;
  assign bus.ram_wdata_o = wdata;
  assign bus.ram_we_o    = rstn_i && bus.memwrite_i && !mis && (region == REG_RAM);

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_q + 32'd1;
  end

  // LED register only takes stores that cover byte lane 0
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      led_o <= '0;
    else if (bus.memwrite_i && !mis && region == REG_LED && be[0])
      led_o <= bus.wdata_i[7:0];
  end

  // Sticky misaligned flag, cleared only by reset
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      misalign_o <= 1'b0;
    else if ((bus.memwrite_i || bus.memread_i) && mis)
      misalign_o <= 1'b1;
  end

  // Capture load context for the result in the next cycle; a store wins over a simultaneous load
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_region_q <= REG_NONE;
      rd_off_q    <= '0;
      rd_sm_q     <= '0;
      rd_mis_q    <= 1'b0;
      rd_snap_q   <= '0;
    end else if (bus.memread_i && !bus.memwrite_i) begin
      rd_region_q <= region;
      rd_off_q    <= off;
      rd_sm_q     <= bus.sign_mask_i;
      rd_mis_q    <= mis;
      rd_snap_q   <= cnt_q;
    end else begin
      rd_region_q <= REG_NONE;
    end
  end

  // Source selection, lane extraction and extension of the load result
  always_comb begin
    case (rd_region_q)
      REG_RAM: src = bus.ram_rdata_i;
      REG_LED: src = {24'b0, led_o};
      REG_CNT: src = rd_snap_q;
      default: src = '0;
    endcase
    if (rd_mis_q) src = '0;
    case (rd_off_q)
      2'd1:    byte_v = src[15:8];
      2'd2:    byte_v = src[23:16];
      2'd3:    byte_v = src[31:24];
      default: byte_v = src[7:0];
    endcase
    half_v = rd_off_q[1] ? src[31:16] : src[15:0];
    case (rd_sm_q[1:0])
      2'b01:   rdata = {{24{rd_sm_q[2] & byte_v[7]}}, byte_v};
      2'b10:   rdata = {{16{rd_sm_q[2] & half_v[15]}}, half_v};
      default: rdata = src;
    endcase
  end

  assign bus.rdata_o = rdata;
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_AWORDS, default 10, meaning log2 of data RAM depth in 32-bit words.
REQ-002 SHALL have parameter RAM_BASE, default 32'h0000_1000, meaning byte base address of the data RAM window.
REQ-003 SHALL have parameter MMIO_BASE, default 32'h0000_2000, meaning byte base address of the MMIO window.
REQ-004 SHALL have the following ports; there is one clock, and reset is asynchronous and active-low:
  clk_i  in  1  rising-edge clock.
  rstn_i  in  1  asynchronous active-low reset.
  addr_i  in  32  byte address from the execute stage.
  wdata_i  in  32  store data, right-aligned.
  memwrite_i  in  1  store request.
  memread_i  in  1  load request.
  sign_mask_i  in  3  [1:0] size: 01 byte, 10 half, 11 word, 00 treated as word; [2] 1 means sign-extend.
  rdata_o  out  32  load result, valid one cycle after the request.
  ram_addr_o  out  RAM_AWORDS  word index to the synchronous RAM.
  ram_wdata_o  out  32  lane-shifted store data.
  ram_be_o  out  4  byte enables.
  ram_we_o  out  1  RAM write strobe.
  ram_rdata_i  in  32  RAM read data, one-cycle latency.
  led_o  out  8  LED register.
  misalign_o  out  1  sticky misaligned-access flag.

Function
REQ-005 SHALL decode each request as one of RAM, LED, CNT or NONE:
  - RAM: addr_i in [RAM_BASE, RAM_BASE + 4*2^RAM_AWORDS).
  - LED: addr_i[31:2] == MMIO_BASE[31:2].
  - CNT: addr_i[31:2] == (MMIO_BASE + 4)[31:2].
  - NONE: any other address.
REQ-006 SHALL flag a request as misaligned when it is a half access with addr_i[0] = 1, or a word access with addr_i[1:0] != 0.
REQ-007 SHALL drive ram_addr_o = (addr_i - RAM_BASE)[RAM_AWORDS+1:2] combinationally in every cycle.
REQ-008 SHALL assert ram_we_o in the same cycle only for an aligned RAM store.
REQ-009 SHALL generate byte enables as follows:
  - byte: 4'b0001 << addr_i[1:0].
  - half: 4'b0011 << addr_i[1:0].
  - word: 4'b1111.
REQ-010 SHALL replicate the store data across lanes: byte as {4{wdata_i[7:0]}}, half as {2{wdata_i[15:0]}}, word as wdata_i.
REQ-011 SHALL, for an aligned LED store, load led_o from wdata_i[7:0] at the clock edge only if byte lane 0 is enabled; other lanes SHALL be ignored.
REQ-012 SHALL ignore stores to CNT and NONE.
REQ-013 SHALL maintain a 32-bit free-running cycle counter that increments every cycle and wraps from 0xFFFF_FFFF to 0.
REQ-014 SHALL register the request region, addr_i[1:0], sign_mask_i and the misaligned flag at every clock edge where memread_i = 1.
REQ-015 SHALL register CNT-region reads as a snapshot of the counter value present in the request cycle.
REQ-016 SHALL, when memread_i = 0, register the region as NONE.
REQ-017 SHALL form rdata_o in cycle N+1 from the registered state, selecting the source word by region:
  - RAM: ram_rdata_i.
  - LED: {24'b0, led_o}.
  - CNT: the snapshot.
  - NONE or misaligned: 0.
REQ-018 SHALL extract the accessed lane from the source word:
  - byte: lane at offset.
  - half: lane at offset[1].
  - word: the whole word.
REQ-019 SHALL extend the extracted lane with its MSB when the registered sign bit is 1, otherwise with zeros.
REQ-020 SHALL treat memwrite_i and memread_i both asserted as a store only; rdata_o SHALL be 0 in the following cycle.
REQ-021 SHALL drop a misaligned access: no RAM write, no LED update, and read data 0.
REQ-022 SHALL set misalign_o at the edge following any misaligned access and hold it at 1 until reset.
REQ-023 SHALL handle back-to-back requests in consecutive cycles without stalls; a load in N+1 after a store in N to the same word SHALL return the stored bytes.

Reset
REQ-024 SHALL, while rstn_i = 0 and independent of clk_i, force led_o = 0, the counter = 0, misalign_o = 0 and the registered region = NONE, so that rdata_o = 0.
REQ-025 SHALL drive ram_we_o = 0 while rstn_i = 0.
REQ-026 SHALL, when reset asserts mid-operation, discard any pending load result; the first request after reset deassertion SHALL behave normally.

Verification
REQ-027 SHALL pass: store word 0xDEADBEEF at 0x1004, then lb at 0x1007 with sign, then lbu at 0x1007 -> rdata_o = 0xFFFFFFDE, then 0x000000DE, each one cycle after its request.
REQ-028 SHALL pass: sh 0x1234 at 0x1002 -> ram_be_o = 4'b1100 and ram_wdata_o = 0x12341234; a following lh at 0x1002 -> 0x00001234.
REQ-029 SHALL pass: sb 0xA5 at 0x2000 -> led_o = 0xA5 after the edge; lw at 0x2000 -> 0x000000A5; sb at 0x2001 -> led_o unchanged.
REQ-030 SHALL pass: lw at 0x1001 -> rdata_o = 0, ram_we_o never asserted, misalign_o = 1 and held through 100 subsequent aligned accesses.
REQ-031 SHALL pass: two lw reads at 0x2004 ten cycles apart, starting 5 cycles after reset release -> results differ by exactly 10; a counter forced to 0xFFFFFFFF reads 0 one cycle later.
REQ-032 SHALL pass: rstn_i pulsed low between a LED store and a subsequent load -> led_o = 0 immediately and rdata_o = 0 in the next cycle.
